uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a FIFO_DEPTH-byte input queue.
// One bit lasts TICKS_PER_BIT clocks; queued frames are sent back to back with no idle gap.
module uart_tx #(
  parameter int TICKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        bit_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = TICKS_PER_BIT > 1 ? $clog2(TICKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic bit_out_q, bit_out_d, busy_q, busy_d;
  logic push, pop, has_data, tick_wrap;

  assign tx_ready   = count_q != (AW+1)'(FIFO_DEPTH);
  assign push       = tx_valid && tx_ready;
  assign has_data   = count_q != '0;
  assign tick_wrap  = tick_q == TW'(TICKS_PER_BIT - 1);
  assign count_d    = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
  assign bit_out    = bit_out_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  always_comb begin
    state_d   = state_q;
    tick_d    = (state_q == IDLE || tick_wrap) ? '0 : tick_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    bit_out_d = bit_out_q;
    busy_d    = busy_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (has_data) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          state_d   = START;
          bit_out_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (tick_wrap) begin
          state_d   = DATA;
          bit_d     = 3'd0;
          bit_out_d = shift_q[0];
        end
      end
      DATA: begin
        if (tick_wrap) begin
          bit_d     = bit_q + 3'd1;
          state_d   = (bit_q == 3'd7) ? STOP : DATA;
          bit_out_d = (bit_q == 3'd7) ? 1'b1 : shift_q[bit_d];
        end
      end
      STOP: begin
        // a queued byte starts its start bit right on the stop-bit wrap
        if (tick_wrap) begin
          pop       = has_data;
          shift_d   = has_data ? mem_q[rd_ptr_q] : shift_q;
          state_d   = has_data ? START : IDLE;
          bit_out_d = !has_data;
          busy_d    = has_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      bit_out_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q  <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q   <= count_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      bit_out_q <= bit_out_d;
      busy_q    <= busy_d;
    end
  end
endmodule
